// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: load sizes, write-back FSM states
// and register-file geometry.
package core_pkg;

  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    LS_BYTE     = 2'b00,
    LS_HALF     = 2'b01,
    LS_WORD     = 2'b10,
    LS_WORD_ALT = 2'b11
  } load_size_e;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/core_wb_load_align.sv
// Combinational load extractor: picks the byte/half/word addressed by the
// load offset out of the bus word and sign- or zero-extends it to 32 bits.
module core_wb_load_align
  import core_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  load_size_e  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  output logic [31:0] data32
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        fill_s;

  // Select the addressed lane, then extend according to size and signedness.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    fill_s = 1'b0;
    data32 = 32'h0000_0000;

    case (offset)
      2'd0:    byte_s = mem_rdata[7:0];
      2'd1:    byte_s = mem_rdata[15:8];
      2'd2:    byte_s = mem_rdata[23:16];
      2'd3:    byte_s = mem_rdata[31:24];
      default: byte_s = 8'h00;
    endcase

    // Halfword loads are assumed aligned; offset[0] does not participate.
    if (offset[1]) begin
      half_s = mem_rdata[31:16];
    end else begin
      half_s = mem_rdata[15:0];
    end

    case (size)
      LS_BYTE: begin
        fill_s = ~is_unsigned & byte_s[7];
        data32 = {{24{fill_s}}, byte_s};
      end
      LS_HALF: begin
        fill_s = ~is_unsigned & half_s[15];
        data32 = {{16{fill_s}}, half_s};
      end
      default: data32 = mem_rdata;
    endcase
  end

endmodule

// File: rtl/core_wb_stage.sv
// Write-back stage: one registered register-file write per instruction, a
// two-state FSM that waits for load data, and a pending-write scoreboard.
module core_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_is_load,
  input  logic [1:0]      in_load_size,
  input  logic            in_load_unsigned,
  input  logic [1:0]      in_load_offset,
  input  logic            mem_rdata_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            reg_write_en,
  output logic [4:0]      reg_write_addr,
  output logic [XLEN-1:0] reg_write_data,
  input  logic [4:0]      id_rs0_addr,
  input  logic [4:0]      id_rs1_addr,
  output logic            id_stall
);

  wb_state_e             state_q, state_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [4:0]            ld_rd_q, ld_rd_d;
  load_size_e            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic                  we_q, we_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  logic                  accept_s;
  logic [NUM_REGS-1:0]   set_mask_s;
  logic [NUM_REGS-1:0]   clr_mask_s;
  logic [31:0]           align_s;

  core_wb_load_align u_align (
    .mem_rdata   (mem_rdata),
    .size        (ld_size_q),
    .is_unsigned (ld_uns_q),
    .offset      (ld_off_q),
    .data32      (align_s)
  );

  assign in_ready       = (state_q == WB_IDLE);
  assign accept_s       = in_valid && in_ready;
  assign reg_write_en   = we_q;
  assign reg_write_addr = waddr_q;
  assign reg_write_data = wdata_q;
  assign id_stall       = ((id_rs0_addr != 5'd0) && pending_q[id_rs0_addr]) ||
                          ((id_rs1_addr != 5'd0) && pending_q[id_rs1_addr]);

  // Next-state, write-port and scoreboard computation.
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_size_d  = ld_size_q;
    ld_uns_d   = ld_uns_q;
    ld_off_d   = ld_off_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    set_mask_s = {NUM_REGS{1'b0}};
    clr_mask_s = {NUM_REGS{1'b0}};

    // The bit clears on the edge where the register file captures the write.
    if (we_q) begin
      clr_mask_s = 32'h0000_0001 << waddr_q;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end

    case (state_q)
      WB_IDLE: begin
        if (accept_s) begin
          if (in_rd != 5'd0) begin
            set_mask_s = 32'h0000_0001 << in_rd;
          end else begin
            set_mask_s = {NUM_REGS{1'b0}};
          end
          if (in_is_load) begin
            ld_rd_d   = in_rd;
            ld_size_d = load_size_e'(in_load_size);
            ld_uns_d  = in_load_unsigned;
            ld_off_d  = in_load_offset;
            state_d   = WB_WAIT_LOAD;
          end else begin
            we_d    = (in_rd != 5'd0);
            waddr_d = in_rd;
            wdata_d = in_result;
          end
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_WAIT_LOAD: begin
        if (mem_rdata_valid) begin
          we_d    = (ld_rd_q != 5'd0);
          waddr_d = ld_rd_q;
          wdata_d = align_s;
          state_d = WB_IDLE;
        end else begin
          state_d = WB_WAIT_LOAD;
        end
      end
      default: state_d = WB_IDLE;
    endcase

    // Set after clear so a same-edge set of a bit wins; x0 never pends.
    pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & ~32'h0000_0001;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      pending_q <= {NUM_REGS{1'b0}};
      ld_rd_q   <= 5'd0;
      ld_size_q <= LS_BYTE;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= 2'd0;
      we_q      <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ld_rd_q   <= ld_rd_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_off_q  <= ld_off_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: doc/core_wb_stage.md
# core_wb_stage

Write-back stage of the core pipeline. Accepts retired results from the execute/memory stage and waits for load data from the data bus. Aligns and sign/zero-extends load data, then drives the register file write port with one registered write per instruction. Holds a 32-bit pending-write scoreboard so the ID stage can stall on a read-after-write hazard.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept; in_valid && in_ready = accept.
- in_rd  in  5  destination register.
- in_result  in  32  ALU/CSR result; ignored for loads.
- in_is_load  in  1  instruction is a load; data comes from mem_rdata.
- in_load_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- in_load_unsigned  in  1  zero-extend (LBU/LHU) instead of sign-extend.
- in_load_offset  in  2  address[1:0] of the load.
- mem_rdata_valid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  32  raw aligned 32-bit word from the data bus.
- reg_write_en  out  1  register file write strobe (registered).
- reg_write_addr  out  5  register file write address (registered).
- reg_write_data  out  32  register file write data (registered).
- id_rs0_addr  in  5  ID source 0 address.
- id_rs1_addr  in  5  ID source 1 address.
- id_stall  out  1  combinational: a nonzero id_rs0/1_addr has its pending bit set.

## Operation
- States: IDLE, WAIT_LOAD. in_ready = (state == IDLE).
- IDLE, accept, !in_is_load: next cycle reg_write_en=1, reg_write_addr=in_rd, reg_write_data=in_result. Stay IDLE, so back-to-back accepts give one write per cycle.
- IDLE, accept, in_is_load: latch rd, size, unsigned, offset, then go to WAIT_LOAD.
- WAIT_LOAD, mem_rdata_valid: next cycle reg_write_en=1 with the extracted data, and state returns to IDLE. in_ready is 0 in the data cycle and 1 in the write cycle.
- Load extraction:
  - byte = mem_rdata[8*offset +: 8];
  - half = mem_rdata[16*offset[1] +: 16], with offset[0] ignored (no misaligned support);
  - word = mem_rdata.
  - Extend to 32 bits: sign-extend unless unsigned.
- rd==0: no register write is issued (reg_write_en stays 0) and no pending bit is set. Loads to x0 still wait for mem_rdata_valid.
- Scoreboard pending[31:1]:
  - A bit is set on the accept edge.
  - It is cleared on the edge where reg_write_en=1 for that address, i.e. the edge at which the register file captures the data.
  - If a set and a clear of the same bit fall on the same edge, the set wins.
- id_stall checks both read ports and ignores address 0.
- mem_rdata_valid in IDLE is ignored, with no write and no state change.
- No load timeout; WAIT_LOAD holds until data or rst.

## Timing
- Reset values: state=IDLE, pending=0, reg_write_en=0, reg_write_addr=0, reg_write_data=0. Consequently in_ready=1 and id_stall=0 after reset.
- Non-load latency: accept at edge N -> reg_write_en high in cycle N..N+1 -> register file write at edge N+1.
- Load latency: mem_rdata_valid sampled at edge K -> reg_write_en high in cycle K..K+1 -> register file write at edge K+1.
- reg_write_en is a one-cycle pulse per instruction and never repeats.
- rst asserted during WAIT_LOAD: return to IDLE, clear pending, no write. A mem_rdata_valid arriving after reset is ignored.
- rst has priority over accept and over mem_rdata_valid in the same cycle.
- in_valid while in_ready=0: upstream holds its inputs; nothing is sampled.

## Structure
- Shared package core_pkg:
  - load-size typedef with encodings 00/01/10/11;
  - wb state enum {IDLE, WAIT_LOAD};
  - constant for register count 32.
- Sub-module core_wb_load_align: purely combinational extractor with inputs mem_rdata, size, unsigned, offset and output data32. Instantiate it once.
- The FSM, the scoreboard and the output registers stay in core_wb_stage.

## Test plan
- Reset then accept ALU result rd=5, result=0x1234_5678: reg_write_en pulses one cycle later with addr 5 and data 0x1234_5678, and pending[5] is visible as id_stall (id_rs0=5) only during the cycle between accept and write.
- Load byte, signed, offset 2, mem_rdata=0x0080_0000 arriving 3 cycles after accept: write data 0xFFFF_FF80 to rd. in_ready stays 0 until the write cycle, and id_stall stays 1 for rs1=rd throughout.
- Load half, unsigned, offset 2, mem_rdata=0xBEEF_0000: write data 0x0000_BEEF. The same load with sign extension writes 0xFFFF_BEEF.
- Three back-to-back ALU accepts to rd=1,2,3: three consecutive single-cycle writes, in order, with in_ready constantly 1. An accept to rd=0 produces no write and no stall.
- rst asserted in WAIT_LOAD, followed by mem_rdata_valid: no write occurs, pending=0, in_ready=1 on the cycle after reset.
- Spurious mem_rdata_valid in IDLE: no write and no state change. A subsequent ALU accept behaves normally.
